// File: rtl/pad_cfg_pkg.sv
// Shared definitions for the serial pad-configuration loader: frame field
// positions, counter limits, reset configuration and the FSM state type.
package pad_cfg_pkg;

    localparam int CFG_W   = 6;
    localparam int FRAME_W = 16;

    // Field positions inside a complete 16-bit frame
    localparam int R_BIT   = 15;
    localparam int IDX_MSB = 14;
    localparam int IDX_LSB = 9;
    localparam int IDX_W   = IDX_MSB - IDX_LSB + 1;

    // After 8 shifted bits the R flag and index sit lower in the shifter
    localparam int RD_R_BIT   = 7;
    localparam int RD_IDX_LSB = 1;
    localparam int RD_W       = 8;

    // Bit positions of {oe, cs, sl, pu, pd, ie} inside a pad config word
    localparam int CFG_OE = 5;
    localparam int CFG_CS = 4;
    localparam int CFG_SL = 3;
    localparam int CFG_PU = 2;
    localparam int CFG_PD = 1;
    localparam int CFG_IE = 0;

    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_FULL    = 5'd16;
    localparam logic [CNT_W-1:0] CNT_MAX     = 5'd17;
    localparam logic [CNT_W-1:0] CNT_RD_PRE  = 5'd7;
    localparam logic [CNT_W-1:0] CNT_RD_LOAD = 5'd8;

    // Input enable on, everything else off
    localparam logic [CFG_W-1:0] CFG_RST = 6'b000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Bit counter stops at 17 so any over-length frame stays distinguishable
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 5'd1;
    endfunction

endpackage

// File: rtl/pad_cfg_loader_sync_edge.sv
// sync_edge: multi-stage synchronizer for one asynchronous pin, plus an
// extra register that turns level changes into one-cycle rise/fall pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    // Shift the pin through the synchronizer; remember last synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the pin's idle level so release never fakes an edge
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/pad_cfg_loader.sv
// pad_cfg_loader: receives 16-bit addressed frames on a slow three-wire
// serial port (sampled through io_in) and holds a 6-bit config per pad.
// Optional feature macro: PAD_CFG_READBACK_EN (read frames shift the
// addressed pad config back out on cfg_sdo).
module pad_cfg_loader
    import pad_cfg_pkg::*;
#(
    parameter int NPADS       = 43,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             cfg_sck,
    input  logic             cfg_sdi,
    input  logic             cfg_csn,
    output logic             cfg_sdo,
    output logic             cfg_sdo_oe,
    input  logic             err_clr,
    output logic             frame_err,
    output logic             commit,
    output logic [NPADS-1:0] io_oe,
    output logic [NPADS-1:0] io_cs,
    output logic [NPADS-1:0] io_sl,
    output logic [NPADS-1:0] io_pu,
    output logic [NPADS-1:0] io_pd,
    output logic [NPADS-1:0] io_ie
);

    logic sck_lvl, sck_rise, sck_fall;
    logic sdi_lvl, sdi_rise, sdi_fall;
    logic csn_lvl, csn_rise, csn_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk_i(clk_i), .rst_n(rst_n), .din(cfg_sck),
        .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk_i(clk_i), .rst_n(rst_n), .din(cfg_sdi),
        .level(sdi_lvl), .rise(sdi_rise), .fall(sdi_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk_i(clk_i), .rst_n(rst_n), .din(cfg_csn),
        .level(csn_lvl), .rise(csn_rise), .fall(csn_fall)
    );

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [FRAME_W-1:0]            sh_q, sh_d;
    logic [NPADS-1:0][CFG_W-1:0]   cfg_q, cfg_d;
    logic                          commit_q, commit_d;
    logic                          frame_err_q, frame_err_d;
    logic                          err_set;

    // Decode of the captured frame, only meaningful in CHECK
    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_ext;
    logic             len_ok, read_frame, idx_ok, frame_ok;

    assign idx        = sh_q[IDX_MSB:IDX_LSB];
    assign idx_ext    = 32'(idx);
    assign len_ok     = (cnt_q == CNT_FULL);
    assign read_frame = len_ok & sh_q[R_BIT];
    assign idx_ok     = (idx_ext < 32'(NPADS));
    assign frame_ok   = len_ok & ~sh_q[R_BIT] & idx_ok;

    // Frame FSM: collect bits while csn is low, judge the frame on csn rise
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        cfg_d       = cfg_q;
        commit_d    = 1'b0;
        frame_err_d = frame_err_q;
        err_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!csn_lvl) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            ST_SHIFT: begin
                if (csn_rise) begin
                    state_d = ST_CHECK;
                end else if (sck_rise) begin
                    sh_d  = {sh_q[FRAME_W-2:0], sdi_lvl};
                    cnt_d = cnt_inc(cnt_q);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok) begin
                    commit_d = 1'b1;
                    for (int i = 0; i < NPADS; i++) begin
                        if (idx_ext == i) cfg_d[i] = sh_q[CFG_W-1:0];
                    end
                end else if (!read_frame) begin
                    err_set = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new error in the same cycle as err_clr keeps the flag set
        if (err_set)      frame_err_d = 1'b1;
        else if (err_clr) frame_err_d = 1'b0;
    end

    // State, shifter, pad configuration and status registers
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            cfg_q       <= {NPADS{CFG_RST}};
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            cfg_q       <= cfg_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign commit    = commit_q;
    assign frame_err = frame_err_q;

    for (genvar i = 0; i < NPADS; i++) begin : g_pad
        assign io_oe[i] = cfg_q[i][CFG_OE];
        assign io_cs[i] = cfg_q[i][CFG_CS];
        assign io_sl[i] = cfg_q[i][CFG_SL];
        assign io_pu[i] = cfg_q[i][CFG_PU];
        assign io_pd[i] = cfg_q[i][CFG_PD];
        assign io_ie[i] = cfg_q[i][CFG_IE];
    end

`ifdef PAD_CFG_READBACK_EN
    logic [RD_W-1:0]  rd_sh_q, rd_sh_d;
    logic             sdo_oe_q, sdo_oe_d;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_idx_ext;
    logic [CFG_W-1:0] rd_cfg;

    // Index as it will sit in the shifter once the 8th bit is taken
    assign rd_idx     = sh_d[RD_R_BIT-1:RD_IDX_LSB];
    assign rd_idx_ext = 32'(rd_idx);

    // Load the addressed config at bit 8 of a read frame, then present one
    // bit per sck fall so the master samples it on the following rise
    always_comb begin
        rd_sh_d  = rd_sh_q;
        sdo_oe_d = sdo_oe_q;
        rd_cfg   = '0;
        for (int i = 0; i < NPADS; i++) begin
            if (rd_idx_ext == i) rd_cfg = cfg_q[i];
        end
        case (state_q)
            ST_SHIFT: begin
                if (!csn_rise && sck_rise && cnt_q == CNT_RD_PRE && sh_d[RD_R_BIT]) begin
                    rd_sh_d  = {2'b00, rd_cfg};
                    sdo_oe_d = 1'b1;
                end else if (!csn_rise && sck_fall && sdo_oe_q && cnt_q > CNT_RD_LOAD) begin
                    rd_sh_d = {rd_sh_q[RD_W-2:0], 1'b0};
                end
            end
            default: begin
                rd_sh_d  = '0;
                sdo_oe_d = 1'b0;
            end
        endcase
    end

    // Readback output shifter
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_sh_q  <= '0;
            sdo_oe_q <= 1'b0;
        end else begin
            rd_sh_q  <= rd_sh_d;
            sdo_oe_q <= sdo_oe_d;
        end
    end

    assign cfg_sdo    = rd_sh_q[RD_W-1];
    assign cfg_sdo_oe = sdo_oe_q;
`else
    assign cfg_sdo    = 1'b0;
    assign cfg_sdo_oe = 1'b0;
`endif

    // Edge pulses not needed by this block
    logic unused_edges;
    assign unused_edges = ^{sdi_rise, sdi_fall, csn_fall, sck_lvl, sck_fall};

endmodule

// File: tb/tb_pad_cfg_loader.sv
// Scoreboard bench for pad_cfg_loader: stimulus pushes the expected pad
// state for each commit / frame-error event, a monitor pops and compares.
module tb_pad_cfg_loader;

    localparam int NPADS = 43;
    localparam int PW    = NPADS * 6;

    localparam int K_COMMIT = 0;
    localparam int K_ERR    = 1;

    logic             clk_i = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_sck = 1'b0;
    logic             cfg_sdi = 1'b0;
    logic             cfg_csn = 1'b1;
    logic             err_clr = 1'b0;
    logic             cfg_sdo, cfg_sdo_oe, frame_err, commit;
    logic [NPADS-1:0] io_oe, io_cs, io_sl, io_pu, io_pd, io_ie;

    pad_cfg_loader #(.NPADS(NPADS), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cfg_sck(cfg_sck), .cfg_sdi(cfg_sdi), .cfg_csn(cfg_csn),
        .cfg_sdo(cfg_sdo), .cfg_sdo_oe(cfg_sdo_oe),
        .err_clr(err_clr), .frame_err(frame_err), .commit(commit),
        .io_oe(io_oe), .io_cs(io_cs), .io_sl(io_sl),
        .io_pu(io_pu), .io_pd(io_pd), .io_ie(io_ie)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          is_commit;
        logic [PW-1:0] pads;
    } exp_t;

    typedef struct {
        logic [31:0] v;
        int          n;
        int          kind;
        int          pad;
        logic [5:0]  cfg;
    } vec_t;

    exp_t          exp_q[$];
    logic [PW-1:0] model;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [PW-1:0] pads_now();
        logic [PW-1:0] v;
        for (int p = 0; p < NPADS; p++)
            v[p*6 +: 6] = {io_oe[p], io_cs[p], io_sl[p], io_pu[p], io_pd[p], io_ie[p]};
        return v;
    endfunction

    function automatic logic [PW-1:0] reset_pads();
        logic [PW-1:0] v;
        for (int p = 0; p < NPADS; p++) v[p*6 +: 6] = 6'b000001;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_pads(input string name, input logic [PW-1:0] exp);
        checks++;
        if (pads_now() !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, pads_now(), exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk_pads({name, "_pads"}, reset_pads());
        chk({name, "_ie"}, 64'(io_ie), {21'd0, {NPADS{1'b1}}});
        chk({name, "_oe"}, 64'(io_oe | io_cs | io_sl | io_pu | io_pd), 64'd0);
        chk({name, "_err"}, 64'(frame_err), 64'd0);
        chk({name, "_commit"}, 64'(commit), 64'd0);
        chk({name, "_sdo"}, 64'({cfg_sdo, cfg_sdo_oe}), 64'd0);
    endtask

    // One serial bit: setup, sck high, sck low; sdo sampled just before rise
    task automatic sck_bit(input logic b, output logic sdo_s);
        cfg_sdi = b;
        tick(3);
        sdo_s = cfg_sdo;
        cfg_sck = 1'b1;
        tick(6);
        cfg_sck = 1'b0;
        tick(3);
    endtask

    task automatic send_frame(input logic [31:0] v, input int n, output logic [7:0] rd);
        logic s;
        rd = 8'h00;
        cfg_csn = 1'b0;
        tick(6);
        for (int k = 0; k < n; k++) begin
            sck_bit(v[n-1-k], s);
            if (k >= 8 && k < 16) rd = {rd[6:0], s};
        end
        tick(3);
        cfg_csn = 1'b1;
        tick(10);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            tick(1);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d events pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
        chk("err_clr", 64'(frame_err), 64'd0);
    endtask

    // Monitor: every commit pulse or frame_err rise consumes one expectation
    initial begin : monitor
        exp_t e;
        logic err_prev;
        logic commit_prev;
        err_prev = 1'b0;
        commit_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (commit_prev) begin
                checks++;
                if (commit) begin
                    errors++;
                    $display("FAIL commit_width: commit high %0d cycles, expected 1", 2);
                end
            end
            if (commit || (frame_err && !err_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: commit=%0b frame_err=%0b, expected no event", commit, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind_commit", 64'(commit), 64'(e.is_commit));
                    chk_pads("event_pads", e.pads);
                end
            end
            commit_prev = commit;
            err_prev = frame_err;
        end
    end

    vec_t       vecs[8];
    logic [7:0] rd;
    logic [7:0] exp_rd;
    exp_t       ev;

    initial begin : stim
        // Hand-computed frames and their effect
        vecs[0] = '{32'h0A3F,  16, K_COMMIT, 5,  6'h3F};  // pad 5, all bits set
        vecs[1] = '{32'h5621,  16, K_ERR,    0,  6'h00};  // index 43 out of range
        vecs[2] = '{32'h0615,  15, K_ERR,    0,  6'h00};  // short frame
        vecs[3] = '{32'h00C15, 17, K_ERR,    0,  6'h00};  // long frame
        vecs[4] = '{32'h0000,  0,  K_ERR,    0,  6'h00};  // csn pulse, no sck
        vecs[5] = '{32'h7E3F,  16, K_ERR,    0,  6'h00};  // index 63
        vecs[6] = '{32'h542A,  16, K_COMMIT, 42, 6'h2A};  // last pad
        vecs[7] = '{32'h05C7,  16, K_COMMIT, 2,  6'h07};  // reserved bits set

        rst_n = 1'b0;
        tick(2);
        chk_reset("reset");
        rst_n = 1'b1;
        tick(5);
        model = reset_pads();

        // sck toggling with csn high must be ignored
        for (int k = 0; k < 4; k++) begin
            cfg_sck = 1'b1; tick(4); cfg_sck = 1'b0; tick(4);
        end
        chk_pads("sck_idle", model);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].kind == K_ERR) clear_err();
            if (vecs[i].kind == K_COMMIT) model[vecs[i].pad*6 +: 6] = vecs[i].cfg;
            ev.is_commit = (vecs[i].kind == K_COMMIT);
            ev.pads = model;
            exp_q.push_back(ev);
            send_frame(vecs[i].v, vecs[i].n, rd);
            drain($sformatf("vec%0d", i));
            if (vecs[i].kind == K_ERR) chk($sformatf("vec%0d_err", i), 64'(frame_err), 64'd1);
        end

        // pad 0 written to zero: ie of pad 0 drops, others keep theirs
        model[0 +: 6] = 6'h00;
        ev.is_commit = 1'b1;
        ev.pads = model;
        exp_q.push_back(ev);
        send_frame(32'h0000, 16, rd);
        drain("pad0_zero");
        chk("pad0_ie", 64'(io_ie[0]), 64'd0);

        // Readback of pad 5, out-of-range index, and last pad
        clear_err();
`ifdef PAD_CFG_READBACK_EN
        exp_rd = 8'h3F;
`else
        exp_rd = 8'h00;
`endif
        send_frame(32'h8A00, 16, rd);
        chk("rd_pad5", 64'(rd), 64'(exp_rd));
        chk("rd_pad5_err", 64'(frame_err), 64'd0);
        chk("rd_pad5_oe", 64'(cfg_sdo_oe), 64'd0);
        send_frame(32'hD600, 16, rd);
        chk("rd_idx43", 64'(rd), 64'd0);
        chk("rd_idx43_err", 64'(frame_err), 64'd0);
`ifdef PAD_CFG_READBACK_EN
        exp_rd = 8'h2A;
`else
        exp_rd = 8'h00;
`endif
        send_frame(32'hD400, 16, rd);
        chk("rd_pad42", 64'(rd), 64'(exp_rd));
        chk_pads("rd_no_change", model);

        // Reset in the middle of a frame, then a fresh write
        cfg_csn = 1'b0;
        tick(6);
        for (int k = 0; k < 9; k++) begin
            logic s;
            sck_bit(1'(16'h0A3F >> (15 - k)), s);
        end
        rst_n = 1'b0;
        tick(2);
        cfg_csn = 1'b1;
        chk_reset("midrst");
        tick(1);
        rst_n = 1'b1;
        tick(6);
        model = reset_pads();
        model[0 +: 6] = 6'h02;
        ev.is_commit = 1'b1;
        ev.pads = model;
        exp_q.push_back(ev);
        send_frame(32'h0002, 16, rd);
        drain("post_rst");
        chk("post_rst_pd0", 64'(io_pd[0]), 64'd1);
        chk("post_rst_err", 64'(frame_err), 64'd0);

        tick(5);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
